// File: rtl/piso_shift_register_if.sv
// piso_shift_register_if: load handshake and serial output bundle for the PISO transmit register
interface piso_shift_register_if #(
    parameter int N = 8
);
    logic [N-1:0]             I;
    logic                     load_valid;
    logic                     load_ready;
    logic                     shift_en;
    logic                     sout;
    logic                     busy;
    logic                     done;
    logic [$clog2(N+1)-1:0]   bit_cnt;

    modport master (
        output I, load_valid, shift_en,
        input  load_ready, sout, busy, done, bit_cnt
    );

    modport slave (
        input  I, load_valid, shift_en,
        output load_ready, sout, busy, done, bit_cnt
    );
endinterface

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in serial-out transmitter, MSB-first (LSB-first when PISO_LSB_FIRST_EN is defined)
module piso_shift_register #(
    parameter int   N          = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input logic                   clk,
    input logic                   reset_n,
    piso_shift_register_if.slave  bus
);
    localparam int W = $clog2(N+1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           sout_q, sout_d;
    logic           done_q, done_d;
    logic           first_bit, next_bit;
    logic [N-1:0]   sr_shifted;

`ifdef PISO_LSB_FIRST_EN
    assign first_bit  = bus.I[0];
    assign next_bit   = sr_q[1];
    assign sr_shifted = sr_q >> 1;
`else
    assign first_bit  = bus.I[N-1];
    assign next_bit   = sr_q[N-2];
    assign sr_shifted = sr_q << 1;
`endif

    // Next-state: accept a word in IDLE, advance one bit per shift_en tick in SHIFT
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.load_valid) begin
                state_d = SHIFT;
                sr_d    = bus.I;
                cnt_d   = W'(N);
                sout_d  = first_bit;
            end
        end else if (bus.shift_en) begin
            if (cnt_q == W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                sout_d  = IDLE_LEVEL;
                done_d  = 1'b1;
            end else begin
                sr_d   = sr_shifted;
                cnt_d  = cnt_q - W'(1);
                sout_d = next_bit;
            end
        end
    end

    // State registers; reset aborts any word in flight and suppresses done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.sout       = sout_q;
    assign bus.done       = done_q;
    assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: directed self-checking bench for piso_shift_register (N = 8)
module tb_piso_shift_register;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    piso_shift_register_if #(.N(8)) bus ();

    piso_shift_register #(.N(8), .IDLE_LEVEL(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Packed status: {sout, busy, load_ready, done, bit_cnt[3:0]}
    logic [7:0] st;
    assign st = {bus.sout, bus.busy, bus.load_ready, bus.done, bus.bit_cnt};

    localparam logic [7:0] IDLE_ST = 8'b1_0_1_0_0000;
    localparam logic [7:0] DONE_ST = 8'b1_0_1_1_0000;

    function automatic logic [7:0] shifting(input logic b, input int cnt);
        return {b, 1'b1, 1'b0, 1'b0, 4'(cnt)};
    endfunction

    // i-th transmitted bit of word w
    function automatic logic ser(input logic [7:0] w, input int i);
`ifdef PISO_LSB_FIRST_EN
        return w[i];
`else
        return w[7-i];
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Load w with shift_en high, check every bit, the done pulse and the return to idle
    task automatic send(input logic [7:0] w, input string tag);
        bus.I          = w;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus.load_valid = 1'b0;
            chk($sformatf("%s_bit%0d", tag, i), st, shifting(ser(w, i), 8 - i));
        end
        @(negedge clk);
        chk({tag, "_done"}, st, DONE_ST);
        @(negedge clk);
        chk({tag, "_idle"}, st, IDLE_ST);
    endtask

    initial begin
        bus.I          = '0;
        bus.load_valid = 1'b0;
        bus.shift_en   = 1'b0;

        // Asynchronous reset assertion
        #2 reset_n = 1'b0;
        #1 chk("reset_async", st, IDLE_ST);
        @(negedge clk);
        chk("reset_held", st, IDLE_ST);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_%0d", i), st, IDLE_ST);
        end

        // shift_en is ignored in IDLE
        bus.shift_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_shift_en", st, IDLE_ST);

        // Single word, shift_en tied high
        send(8'hA5, "a5");
        chk("a5_seq_const", {8{1'b0}} | {ser(8'hA5,0), ser(8'hA5,1), ser(8'hA5,2), ser(8'hA5,3),
                                          ser(8'hA5,4), ser(8'hA5,5), ser(8'hA5,6), ser(8'hA5,7)},
`ifdef PISO_LSB_FIRST_EN
            8'b10100101);
`else
            8'b10100101);
`endif

        // Rate pacing: one tick every 4 cycles, each bit held 4 cycles
        bus.I          = 8'h3C;
        bus.load_valid = 1'b1;
        bus.shift_en   = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            bus.load_valid = 1'b0;
            chk($sformatf("pace_c%0d", c), st, shifting(ser(8'h3C, c / 4), 8 - c / 4));
            bus.shift_en = (c % 4 == 3);
        end
        @(negedge clk);
        chk("pace_done", st, DONE_ST);
        bus.shift_en = 1'b1;
        @(negedge clk);
        chk("pace_idle", st, IDLE_ST);

        // Back-to-back: load_valid held high, second word taken in the done cycle
        bus.I          = 8'hFF;
        bus.load_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ff_%0d", c), st, shifting(1'b1, 8 - c));
            if (c == 0) bus.I = 8'h00;
        end
        @(negedge clk);
        chk("b2b_gap_done", st, DONE_ST);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) bus.load_valid = 1'b0;
            chk($sformatf("b2b_00_%0d", c), st, shifting(1'b0, 8 - c));
        end
        @(negedge clk);
        chk("b2b_done2", st, DONE_ST);
        @(negedge clk);
        chk("b2b_idle", st, IDLE_ST);

        // Abort after 3 bits of C3
        bus.I          = 8'hC3;
        bus.load_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.load_valid = 1'b0;
            chk($sformatf("abort_bit%0d", c), st, shifting(ser(8'hC3, c), 8 - c));
        end
        #2 reset_n = 1'b0;
        #1 chk("abort_async", st, IDLE_ST);
        @(negedge clk);
        chk("abort_no_done", st, IDLE_ST);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", st, IDLE_ST);
        send(8'h81, "x81");

        // Single-bit word 01 shows bit ordering
        send(8'h01, "x01");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out transmit register. It is the serializing counterpart to the team's parallel capture registers.
- Accepts an N-bit word through a valid/ready load handshake, then shifts the word out one bit per shift_en tick on a single serial line.
- Sits between a word-wide producer and a bit-serial link. shift_en comes from an external baud/rate divider.

Parameters:
- N, 8, word width in bits; N >= 2
- IDLE_LEVEL, 1'b1, value driven on sout whenever no word is being shifted

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- I  input  N  parallel word to transmit; sampled only on an accepted load
- load_valid  input  1  producer asserts when I holds a word to send
- load_ready  output  1  block can accept a word this cycle
- shift_en  input  1  bit-rate tick; advances the serial output by one bit
- sout  output  1  serial data out, registered
- busy  output  1  high while a word is being shifted
- done  output  1  one-cycle pulse after the last bit's shift_en tick
- bit_cnt  output  $clog2(N+1)  bits remaining in the current word, including the one on sout

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset_n is asynchronous, active-low. Assertion immediately forces the reset state. Deassertion is taken synchronously by the design.
- Reset state:
  - FSM = IDLE
  - shift register = 0
  - bit_cnt = 0
  - sout = IDLE_LEVEL
  - busy = 0, done = 0
  - load_ready = 1
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - load_ready = 1, busy = 0, sout = IDLE_LEVEL, bit_cnt = 0. shift_en is ignored.
  - Load accepted on a rising edge where load_valid & load_ready = 1. On that edge: shift register <= I, bit_cnt <= N, FSM <= SHIFT.
  - Latency: the first bit appears on sout in the cycle after acceptance.
- SHIFT:
  - load_ready = 0, busy = 1. load_valid is ignored, and I changes have no effect.
  - sout = shift register bit N-1 (MSB-first), registered. Each bit is held until a shift_en tick.
  - On shift_en = 1 with bit_cnt > 1: shift register shifts left by 1 (zero fill), bit_cnt decrements.
  - On shift_en = 1 with bit_cnt == 1 (last bit): FSM <= IDLE, bit_cnt <= 0, sout <= IDLE_LEVEL, and done pulses high for exactly the next cycle.
  - shift_en held high continuously gives one bit per clk. A word then occupies exactly N cycles in SHIFT.
- Back-to-back words:
  - load_ready returns high in the same cycle done is high.
  - A load accepted in that cycle starts the next word with no extra idle cycle beyond the done cycle.
  - A new word is never accepted while busy = 1.
- Reset mid-word: the word is aborted immediately, no done pulse is generated, and all outputs return to reset values.
- done and load_valid in the same cycle: the load is accepted and done still pulses.

Optional Feature:
- Macro: PISO_LSB_FIRST_EN
- Defined:
  - sout = shift register bit 0.
  - Each tick shifts right with zero fill, so the word is transmitted LSB-first.
  - All timing, handshake and counter behaviour is identical to the default build.
- Undefined: MSB-first as described under Behaviour.

Test Plan:
- Reset checks:
  - Assert reset_n = 0 -> sout = 1, busy = 0, load_ready = 1, done = 0, bit_cnt = 0.
  - Release reset with no load_valid -> outputs stay at those values for 10 cycles.
- Single word, N = 8, MSB-first, shift_en tied high:
  - Stimulus: load I = 8'hA5.
  - sout sequence = 1,0,1,0,0,1,0,1 over 8 consecutive cycles.
  - busy high for exactly 8 cycles; bit_cnt counts 8 down to 1.
  - done high for 1 cycle after the last bit, then sout = 1.
- Rate pacing: shift_en pulses once every 4 cycles, load I = 8'h3C -> each bit held exactly 4 cycles; sequence 0,0,1,1,1,1,0,0.
- Back-to-back:
  - Stimulus: load_valid held high with I = 8'hFF, then 8'h00.
  - Second load is accepted in the done cycle.
  - Exactly one IDLE_LEVEL cycle separates the words.
  - load_valid pulses while busy = 1 are ignored (load_ready = 0).
- Abort:
  - Stimulus: assert reset_n = 0 after 3 bits of 8'hC3.
  - sout = 1 immediately (asynchronous) and no done pulse.
  - Next load of 8'h81 transmits cleanly.
- With PISO_LSB_FIRST_EN defined, load I = 8'h01 -> sout sequence 1,0,0,0,0,0,0,0; timing identical to the MSB-first case.
